// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin arbiter sharing one parallel-to-serial serializer among N_CH channels.
// Optional PRESENT-phase watchdog with sticky o_err is enabled by defining SER_ARB_WDOG_EN.
module serializer_arbiter #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned LENGTH      = 24,
   parameter int unsigned WDOG_CYCLES = 256
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   input  logic [N_CH*LENGTH-1:0]    iv_din,
   input  logic [N_CH-1:0]           iv_din_valid,
   output logic [N_CH-1:0]           ov_ack,
   output logic [LENGTH-1:0]         ov_ser_din,
   output logic                      o_ser_din_valid,
   input  logic                      i_ser_ready,
   output logic [$clog2(N_CH)-1:0]   ov_ch_id,
   output logic                      o_busy,
   output logic                      o_err
);

   localparam int unsigned CH_W = $clog2(N_CH);
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

   if (N_CH < 2 || WDOG_CYCLES < 1) begin : g_cfg_err
      $error("serializer_arbiter: N_CH must be >= 2 and WDOG_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_ACK     = 2'd2
   } state_e;

   state_e              state_q;
   logic [CH_W-1:0]     ptr_q;
   logic [CH_W-1:0]     ch_q;
   logic [LENGTH-1:0]   din_q;
   logic                valid_q;
   logic                busy_q;
   logic [N_CH-1:0]     ack_q;

   logic                found_d;
   logic [CH_W-1:0]     ch_d;
   logic [LENGTH-1:0]   din_d;

   // Round-robin pick: first requesting channel starting just after the last served one.
   always_comb begin
      found_d = 1'b0;
      ch_d    = '0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         int unsigned cand;
         cand = (32'(ptr_q) + i) % N_CH;
         if (!found_d && iv_din_valid[CH_W'(cand)]) begin
            found_d = 1'b1;
            ch_d    = CH_W'(cand);
         end
      end
      din_d = iv_din[ch_d*LENGTH +: LENGTH];
   end

`ifdef SER_ARB_WDOG_EN
   logic [WD_W-1:0] wd_q;
   logic            err_q;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= CH_W'(N_CH - 1);
         ch_q    <= '0;
         din_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= '0;
`ifdef SER_ARB_WDOG_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else if (i_en) begin
         ack_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (found_d) begin
                  din_q   <= din_d;
                  ch_q    <= ch_d;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_PRESENT;
`ifdef SER_ARB_WDOG_EN
                  wd_q    <= '0;
`endif
               end
            end
            ST_PRESENT: begin
               // A ready arriving on the limit cycle takes priority over the timeout.
               if (i_ser_ready) begin
                  valid_q <= 1'b0;
                  ack_q   <= N_CH'(1) << ch_q;
                  state_q <= ST_ACK;
               end
`ifdef SER_ARB_WDOG_EN
               else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b1;
                  ack_q   <= N_CH'(1) << ch_q;
                  state_q <= ST_ACK;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
`endif
            end
            ST_ACK: begin
               ptr_q   <= ch_q;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ov_ack          = ack_q;
   assign ov_ser_din      = din_q;
   assign o_ser_din_valid = valid_q;
   assign ov_ch_id        = ch_q;
   assign o_busy          = busy_q;
`ifdef SER_ARB_WDOG_EN
   assign o_err           = err_q;
`else
   assign o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// tb_serializer_arbiter: randomized transfers checked against a transaction-level round-robin model.
// Watchdog checks are built only when SER_ARB_WDOG_EN is defined.
module tb_serializer_arbiter;

   localparam int N  = 4;
   localparam int L  = 24;
   localparam int WD = 16;
   localparam int CW = $clog2(N);

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_en = 1'b1;
   logic [N*L-1:0]    iv_din = '0;
   logic [N-1:0]      iv_din_valid = '0;
   logic [N-1:0]      ov_ack;
   logic [L-1:0]      ov_ser_din;
   logic              o_ser_din_valid;
   logic              i_ser_ready = 1'b0;
   logic [CW-1:0]     ov_ch_id;
   logic              o_busy;
   logic              o_err;

   int n_tests = 0;
   int n_fail  = 0;
   int last_ch = N - 1;

   serializer_arbiter #(.N_CH(N), .LENGTH(L), .WDOG_CYCLES(WD)) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_en            (i_en),
      .iv_din          (iv_din),
      .iv_din_valid    (iv_din_valid),
      .ov_ack          (ov_ack),
      .ov_ser_din      (ov_ser_din),
      .o_ser_din_valid (o_ser_din_valid),
      .i_ser_ready     (i_ser_ready),
      .ov_ch_id        (ov_ch_id),
      .o_busy          (o_busy),
      .o_err           (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: first requester strictly after the last served channel, wrapping.
   function automatic int rr_pick(input int last, input logic [N-1:0] mask);
      for (int k = 1; k <= N; k++) begin
         if (mask[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 64'(o_ser_din_valid), 64'(0));
      chk({tag, "_busy"},  64'(o_busy), 64'(0));
      chk({tag, "_ack"},   64'(ov_ack), 64'(0));
   endtask

   // One full transfer; called at posedge+1 with the DUT idle and i_en high.
   task automatic do_xfer(input logic [N-1:0] mask, input int delay, input bit scr,
                          input logic [L-1:0] scr_word, input bit freeze);
      int              exp_ch;
      logic [L-1:0]    word;
      logic [N-1:0]    oh;
      exp_ch = rr_pick(last_ch, mask);
      word   = iv_din[exp_ch*L +: L];
      oh     = N'(1) << exp_ch;
      iv_din_valid = mask;
      step();
      chk("grant_valid", 64'(o_ser_din_valid), 64'(1));
      chk("grant_ch",    64'(ov_ch_id), 64'(exp_ch));
      chk("grant_word",  64'(ov_ser_din), 64'(word));
      chk("grant_busy",  64'(o_busy), 64'(1));
      chk("grant_ack",   64'(ov_ack), 64'(0));
      if (scr) begin
         iv_din[exp_ch*L +: L] = scr_word;
         iv_din_valid[exp_ch]  = 1'b0;
      end
      for (int c = 0; c < delay; c++) begin
         if (freeze && c < 5) begin
            i_en        = 1'b0;
            i_ser_ready = c[0];
         end else begin
            i_en        = 1'b1;
            i_ser_ready = 1'b0;
         end
         step();
         chk("hold_valid", 64'(o_ser_din_valid), 64'(1));
         chk("hold_word",  64'(ov_ser_din), 64'(word));
         chk("hold_ch",    64'(ov_ch_id), 64'(exp_ch));
         chk("hold_ack",   64'(ov_ack), 64'(0));
      end
      i_en        = 1'b1;
      i_ser_ready = 1'b1;
      step();
      i_ser_ready = 1'b0;
      chk("ack_pulse", 64'(ov_ack), 64'(oh));
      chk("ack_valid", 64'(o_ser_din_valid), 64'(0));
      chk("ack_busy",  64'(o_busy), 64'(1));
      if (freeze) begin
         i_en = 1'b0;
         repeat (2) step();
         chk("ack_frozen", 64'(ov_ack), 64'(oh));
         i_en = 1'b1;
      end
      iv_din_valid = '0;
      step();
      chk_idle("post_ack");
      chk("post_err", 64'(o_err), 64'(0));
      last_ch = exp_ch;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      #1;
      chk("rst_ack",   64'(ov_ack), 64'(0));
      chk("rst_word",  64'(ov_ser_din), 64'(0));
      chk("rst_valid", 64'(o_ser_din_valid), 64'(0));
      chk("rst_ch",    64'(ov_ch_id), 64'(0));
      chk("rst_busy",  64'(o_busy), 64'(0));
      chk("rst_err",   64'(o_err), 64'(0));
      step();
      i_rst_n = 1'b1;
      last_ch = N - 1;
   endtask

   initial begin
      logic [N-1:0] all_mask;
      all_mask = '1;
      for (int k = 0; k < N; k++) iv_din[k*L +: L] = L'(32'hA00000 + k);
      iv_din_valid = all_mask;
      step();
      do_reset();

      // Fairness: all requesting, ready three cycles after each grant.
      for (int g = 0; g < N + 1; g++) begin
         do_xfer(all_mask, 2, 1'b0, '0, 1'b0);
         chk("fair_order", 64'(last_ch), 64'(g % N));
      end

      // Single requester with mid-transfer data change, then enable freeze.
      iv_din[2*L +: L] = L'(32'h5A5A5A);
      do_xfer(N'(4), 2, 1'b1, L'(32'hFFFFFF), 1'b0);
      iv_din[1*L +: L] = L'(32'h123456);
      do_xfer(N'(2), 7, 1'b0, '0, 1'b1);
      repeat (3) step();
      chk_idle("quiet");

      // Asynchronous reset while presenting: aborts, next grant restarts at 0.
      iv_din_valid = N'(8);
      step();
      chk("pre_abort_valid", 64'(o_ser_din_valid), 64'(1));
      #2;
      do_reset();
      do_xfer(all_mask, 1, 1'b0, '0, 1'b0);
      chk("post_abort_ch", 64'(last_ch), 64'(0));

`ifdef SER_ARB_WDOG_EN
      // Ready on the limit cycle wins over the watchdog.
      iv_din_valid = N'(2);
      step();
      for (int c = 0; c < WD - 1; c++) step();
      chk("wd_edge_valid", 64'(o_ser_din_valid), 64'(1));
      i_ser_ready = 1'b1;
      iv_din_valid = '0;
      step();
      i_ser_ready = 1'b0;
      chk("wd_edge_ack", 64'(ov_ack), 64'(2));
      chk("wd_edge_err", 64'(o_err), 64'(0));
      step();
      last_ch = 1;
      // Timeout: valid drops after WD cycles, requester acked, error sticks.
      iv_din_valid = N'(4);
      step();
      for (int c = 0; c < WD - 1; c++) step();
      chk("wd_hold_valid", 64'(o_ser_din_valid), 64'(1));
      iv_din_valid = '0;
      step();
      chk("wd_to_valid", 64'(o_ser_din_valid), 64'(0));
      chk("wd_to_ack",   64'(ov_ack), 64'(4));
      chk("wd_to_err",   64'(o_err), 64'(1));
      repeat (4) step();
      chk_idle("wd_after");
      chk("wd_err_sticky", 64'(o_err), 64'(1));
      do_reset();
`else
      repeat (300) step();
      chk("no_wdog_err", 64'(o_err), 64'(0));
      do_reset();
`endif

      // Randomized transfers against the model.
      for (int t = 0; t < 60; t++) begin
         logic [N-1:0] m;
         bit           fz;
         m = N'($urandom_range(1, (1 << N) - 1));
         for (int k = 0; k < N; k++) iv_din[k*L +: L] = L'($urandom);
         fz = ($urandom_range(0, 3) == 0);
         do_xfer(m, fz ? 6 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 5)),
                 1'($urandom), L'($urandom), fz);
         if ($urandom_range(0, 4) == 0) begin
            step();
            chk_idle("rand_gap");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter that shares one parallel-to-serial serializer among N_CH FIR output channels. Each channel offers a LENGTH-bit word with a valid flag. The arbiter grants one channel at a time, latches its word, and presents it to the serializer's parallel port. When the serializer signals the word consumed, the arbiter acknowledges the requester and moves on. It sits between the FIR channel outputs and the single serial output lane.

## Interface
- N_CH, 4, number of requesting channels (≥2).
- LENGTH, 24, word width; equals the serializer's LENGTH.
- WDOG_CYCLES, 256, watchdog limit in enabled cycles; used only with SER_ARB_WDOG_EN.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  clock enable; when low, all state, counters and outputs hold.
- iv_din  in  N_CH*LENGTH  channel words; channel k occupies bits [k*LENGTH +: LENGTH].
- iv_din_valid  in  N_CH  per-channel request.
- ov_ack  out  N_CH  one-cycle pulse to the channel whose word was consumed (one-hot or zero).
- ov_ser_din  out  LENGTH  latched word to the serializer.
- o_ser_din_valid  out  1  word valid to the serializer.
- i_ser_ready  in  1  serializer's one-cycle "word consumed" pulse.
- ov_ch_id  out  $clog2(N_CH)  index of the granted channel.
- o_busy  out  1  high in any state other than IDLE.
- o_err  out  1  sticky watchdog error.

## Operation
- FSM states: IDLE, PRESENT, ACK.
- IDLE:
  - If any iv_din_valid bit is high, select a channel by round-robin. The search starts at ptr+1 modulo N_CH and takes the first set bit.
  - Latch that channel's word into ov_ser_din and its index into ov_ch_id.
  - Go to PRESENT.
- PRESENT:
  - o_ser_din_valid is high; ov_ser_din and ov_ch_id are held stable.
  - On sampling i_ser_ready=1, go to ACK.
- ACK:
  - ov_ack[ov_ch_id] pulses for exactly one cycle and o_ser_din_valid is low.
  - ptr <= ov_ch_id; go to IDLE.
- The word is committed at grant. Changes to iv_din or iv_din_valid on the granted channel after the grant are ignored until ACK.
- Requesters must hold valid until they see their ack. A valid still high in the cycle after its ack is treated as a new request.
- i_ser_ready is ignored outside PRESENT.
- Reset values:
  - State: IDLE.
  - ptr: N_CH-1, so channel 0 wins first.
  - Outputs: ov_ack, ov_ser_din, o_ser_din_valid, ov_ch_id, o_busy and o_err all 0.
- Reset asserted mid-transfer aborts immediately. No ack is issued and the requester retries after reset.

## Timing
- Request seen in IDLE at edge t:
  - o_ser_din_valid and the latched word appear after edge t.
  - i_ser_ready sampled at edge u → ov_ack pulse after edge u, for one cycle.
  - Return to IDLE after edge u+1.
- Minimum grant-to-grant spacing is 3 cycles. Serializer shift time dominates in practice, because the serializer only samples valid while idle.
- o_ser_din_valid deasserts on the cycle after i_ser_ready is sampled. The serializer therefore sees each word exactly once.
- All outputs are registered; there is no combinational path from inputs to outputs.
- i_en low freezes everything, including ov_ack: a pending ack pulse is extended until i_en returns.
- Fairness: with all channels requesting continuously, grants cycle 0,1,…,N_CH-1,0,… A channel waits at most N_CH-1 other grants.

## Configuration
- SER_ARB_WDOG_EN defined:
  - A counter runs while in PRESENT and resets on entry to PRESENT.
  - If it reaches WDOG_CYCLES without i_ser_ready, drop o_ser_din_valid, set o_err=1 and go to ACK. The requester is released and the word is dropped.
  - o_err clears only on reset.
  - If i_ser_ready arrives in the same cycle the limit is reached, i_ser_ready wins: normal ack and no error.
- SER_ARB_WDOG_EN undefined:
  - No counter; PRESENT waits indefinitely.
  - o_err is tied 0.

## Test plan
- Reset with all four valids high, ser ready after 3 cycles each → grants 0,1,2,3,0 in order, each ack a single pulse, ov_ser_din = the matching channel word (e.g. 24'hA00000+k).
- Only channel 2 valid, word 24'h5A5A5A → ov_ch_id=2, ov_ser_din=24'h5A5A5A, ack[2] pulse one cycle after i_ser_ready, then idle with o_busy=0.
- Change iv_din of the granted channel to 24'hFFFFFF while in PRESENT → ov_ser_din stays at the latched value until ack.
- i_en low for 5 cycles during PRESENT with i_ser_ready pulsed → state and outputs frozen and the pulse ignored; the transfer completes on the next ready after i_en returns.
- Assert i_rst_n=0 asynchronously mid-PRESENT → all outputs 0 immediately, no ack, next grant goes to channel 0.
- With SER_ARB_WDOG_EN, WDOG_CYCLES=16, no i_ser_ready → valid drops after 16 cycles, o_err=1, requester acked, o_err holds until reset.
